// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register for the 64-bit
// pipelined ARM core. Owns the PC, drives the instruction-memory address and
// picks the next PC from sequential / stall / redirect. The fetched word is
// registered together with its PC, PC+4 and the pre-sliced D-type and ADDI
// immediates so decode does not have to re-slice them.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   imem_addr    instruction-memory byte address (== pc)
//   imem_data    instruction word at imem_addr, valid in the same cycle
//   stall        hold pc and IF/ID
//   redirect     taken branch/jump from downstream; flushes IF/ID
//   redirect_pc  redirect target; low two bits are dropped
//   pc           current fetch PC
//   instr_id     IF/ID instruction
//   pc_id        PC of instr_id
//   pc_plus4_id  pc_id + 4 (BL link value)
//   imm9_id      instr[20:12] (D-type offset)
//   imm12_id     instr[21:10] (ADDI immediate)
//   valid_id     IF/ID holds a real instruction (0 = bubble)
//   fetch_count  saturating count of instructions accepted into IF/ID
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] pc,
   output logic [31:0] instr_id,
   output logic [63:0] pc_id,
   output logic [63:0] pc_plus4_id,
   output logic [8:0]  imm9_id,
   output logic [11:0] imm12_id,
   output logic        valid_id,
   output logic [31:0] fetch_count
);

   // Word-aligned redirect target; masking keeps every input bit in use.
   logic [63:0] redirect_tgt;
   logic [63:0] pc_next_seq;

   assign redirect_tgt = redirect_pc & ~64'h3;
   assign pc_next_seq  = pc + 64'd4;   // modulo 2^64, wraps silently

   // Address comes straight from the PC register, so it only moves on a
   // clock edge or reset, never combinationally from stall/redirect.
   assign imem_addr = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         instr_id    <= NOP_INSTR;
         pc_id       <= 64'd0;
         pc_plus4_id <= 64'd0;
         imm9_id     <= NOP_INSTR[20:12];
         imm12_id    <= NOP_INSTR[21:10];
         valid_id    <= 1'b0;
         fetch_count <= 32'd0;
      end else if (redirect) begin
         // Redirect wins over stall: the word in flight is on the wrong path,
         // so replace it with a bubble and restart at the target.
         pc          <= redirect_tgt;
         instr_id    <= NOP_INSTR;
         pc_id       <= 64'd0;
         pc_plus4_id <= 64'd0;
         imm9_id     <= NOP_INSTR[20:12];
         imm12_id    <= NOP_INSTR[21:10];
         valid_id    <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_next_seq;
         instr_id    <= imem_data;
         pc_id       <= pc;
         pc_plus4_id <= pc_next_seq;
         imm9_id     <= imem_data[20:12];
         imm12_id    <= imem_data[21:10];
         valid_id    <= 1'b1;
         if (fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with RESET_PC = 0x100. The instruction
// memory model returns 0xA0000000 | addr[31:0], or a fixed ADDI word while
// imm_mode is set. Inputs change on the falling edge; outputs are checked on
// the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [63:0] pc;
   logic [31:0] instr_id;
   logic [63:0] pc_id;
   logic [63:0] pc_plus4_id;
   logic [8:0]  imm9_id;
   logic [11:0] imm12_id;
   logic        valid_id;
   logic [31:0] fetch_count;

   logic        imm_mode;
   int          errs   = 0;
   int          checks = 0;

   localparam logic [31:0] NOP    = 32'hD503201F;
   localparam logic [8:0]  NOP_I9 = 9'h032;
   localparam logic [11:0] NOP_I12 = 12'h0C8;

   fetch_stage #(.RESET_PC(64'h100), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .instr_id    (instr_id),
      .pc_id       (pc_id),
      .pc_plus4_id (pc_plus4_id),
      .imm9_id     (imm9_id),
      .imm12_id    (imm12_id),
      .valid_id    (valid_id),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      imem_data = 32'hA000_0000 | imem_addr[31:0];
      if (imm_mode) imem_data = 32'h9100_3FE1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".pc"},       pc,          64'h100);
      chk({tag, ".addr"},     imem_addr,   64'h100);
      chk({tag, ".instr"},    {32'd0, instr_id}, {32'd0, NOP});
      chk({tag, ".valid"},    {63'd0, valid_id}, 64'd0);
      chk({tag, ".pc_id"},    pc_id,       64'd0);
      chk({tag, ".pc4"},      pc_plus4_id, 64'd0);
      chk({tag, ".imm9"},     {55'd0, imm9_id},  {55'd0, NOP_I9});
      chk({tag, ".imm12"},    {52'd0, imm12_id}, {52'd0, NOP_I12});
      chk({tag, ".cnt"},      {32'd0, fetch_count}, 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_pc = 64'd0; imm_mode = 1'b0;

      // ---- reset and sequential fetch ----
      do_reset();
      step();
      chk("seq1.valid", {63'd0, valid_id}, 64'd1);
      chk("seq1.pc_id", pc_id, 64'h100);
      chk("seq1.instr", {32'd0, instr_id}, 64'hA000_0100);
      step(); step(); step();
      chk("seq4.pc",    pc,          64'h110);
      chk("seq4.instr", {32'd0, instr_id}, 64'hA000_010C);
      chk("seq4.pc_id", pc_id,       64'h10C);
      chk("seq4.pc4",   pc_plus4_id, 64'h110);
      chk("seq4.cnt",   {32'd0, fetch_count}, 64'd4);

      // ---- stall at pc = 0x108 ----
      do_reset();
      step(); step();
      chk("stall.pre_pc", pc, 64'h108);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.pc",    pc,    64'h108);
         chk("stall.instr", {32'd0, instr_id}, 64'hA000_0104);
         chk("stall.pc_id", pc_id, 64'h104);
         chk("stall.cnt",   {32'd0, fetch_count}, 64'd2);
      end
      stall = 1'b0;
      step();
      chk("resume.pc_id", pc_id, 64'h108);
      chk("resume.pc",    pc,    64'h10C);
      chk("resume.cnt",   {32'd0, fetch_count}, 64'd3);

      // ---- redirect together with stall ----
      redirect = 1'b1; stall = 1'b1; redirect_pc = 64'h2003;
      step();
      chk("rds.pc",    pc, 64'h2000);
      chk("rds.valid", {63'd0, valid_id}, 64'd0);
      chk("rds.instr", {32'd0, instr_id}, {32'd0, NOP});
      chk("rds.pc_id", pc_id, 64'd0);
      chk("rds.imm9",  {55'd0, imm9_id}, {55'd0, NOP_I9});
      chk("rds.cnt",   {32'd0, fetch_count}, 64'd3);
      redirect = 1'b0; stall = 1'b0;
      step();
      chk("rds2.pc_id", pc_id, 64'h2000);
      chk("rds2.valid", {63'd0, valid_id}, 64'd1);
      chk("rds2.instr", {32'd0, instr_id}, 64'hA000_2000);
      chk("rds2.cnt",   {32'd0, fetch_count}, 64'd4);

      // ---- immediates from ADDI X1, XZR, #15 ----
      imm_mode = 1'b1;
      step();
      chk("imm.instr", {32'd0, instr_id}, 64'h9100_3FE1);
      chk("imm.imm12", {52'd0, imm12_id}, 64'h00F);
      chk("imm.imm9",  {55'd0, imm9_id},  64'h003);
      chk("imm.pc_id", pc_id, 64'h2004);
      imm_mode = 1'b0;

      // ---- PC wrap ----
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      chk("wrap.rd_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      redirect = 1'b0;
      step();
      chk("wrap.pc",    pc,          64'd0);
      chk("wrap.pc_id", pc_id,       64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap.pc4",   pc_plus4_id, 64'd0);
      chk("wrap.instr", {32'd0, instr_id}, 64'hFFFF_FFFC);
      step();
      chk("wrap2.pc_id", pc_id, 64'd0);
      chk("wrap2.pc4",   pc_plus4_id, 64'd4);
      chk("wrap2.cnt",   {32'd0, fetch_count}, 64'd7);

      // ---- redirect held two cycles, then back-to-back targets ----
      redirect = 1'b1; redirect_pc = 64'h300;
      step();
      chk("hold1.valid", {63'd0, valid_id}, 64'd0);
      step();
      chk("hold2.valid", {63'd0, valid_id}, 64'd0);
      chk("hold2.pc",    pc, 64'h300);
      redirect_pc = 64'h500;
      step();
      chk("b2b.pc", pc, 64'h500);
      redirect = 1'b0;
      step();
      chk("b2b.pc_id", pc_id, 64'h500);
      chk("b2b.cnt",   {32'd0, fetch_count}, 64'd8);

      // ---- fetch_count saturation from a preloaded count ----
      force dut.fetch_count = 32'hFFFF_FFFD;
      #1;
      release dut.fetch_count;
      step();
      chk("sat1", {32'd0, fetch_count}, 64'hFFFF_FFFE);
      step();
      chk("sat2", {32'd0, fetch_count}, 64'hFFFF_FFFF);
      step();
      chk("sat3", {32'd0, fetch_count}, 64'hFFFF_FFFF);

      // ---- async reset between edges during a redirect ----
      redirect = 1'b1; redirect_pc = 64'h4000;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("arst");
      @(negedge clk);
      redirect = 1'b0;
      reset = 1'b1;
      step();
      chk("arst.pc_id", pc_id, 64'h100);
      chk("arst.cnt",   {32'd0, fetch_count}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
